// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, controller
// states and the sizing rule for the nibble counter.
package nibble_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } nsa_state_t;

    // Counter width needed to index WIDTH/NIB_W nibbles, never narrower than one bit.
    function automatic int cnt_w(input int width);
        int n;
        n = width / NIB_W;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder4.sv
// Four-bit ripple-carry adder; the per-nibble datapath of the serial adder.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       i_c,
    output logic [3:0] sum,
    output logic       o_c
);

    always_comb begin
        logic carry;
        carry = i_c;
        sum   = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        o_c = carry;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that reuses one adder4, processing one nibble per clock
// (LSB first) between a valid/ready input and a valid/ready output handshake.
module nibble_serial_adder
    import nibble_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             i_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             o_c
);

    localparam int NIB = WIDTH / NIB_W;
    localparam int CW  = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(NIB - 1);

    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end

    nsa_state_t       state;
    nsa_state_t       state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [3:0]       nib_sum;
    logic             nib_c;

    adder4 u_adder4 (
        .a   (a_sh[3:0]),
        .b   (b_sh[3:0]),
        .i_c (carry),
        .sum (nib_sum),
        .o_c (nib_c)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (cnt == LAST_CNT) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result fills from the top so the first (least significant) nibble lands at bit 0 after NIB shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            result <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= i_c;
                        result <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    result <= WIDTH'({nib_sum, result} >> NIB_W);
                    carry  <= nib_c;
                    a_sh   <= a_sh >> NIB_W;
                    b_sh   <= b_sh >> NIB_W;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = result;
    assign o_c       = carry;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed cases on 16- and 4-bit instances,
// then concurrent random handshake regression on 16- and 32-bit instances.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // 16-bit instance
    logic        iv16 = 0, ir16, ov16, or16 = 0, ic16 = 0, oc16;
    logic [15:0] a16 = 0, b16 = 0, s16;
    // 4-bit instance
    logic        iv4 = 0, ir4, ov4, or4 = 0, ic4 = 0, oc4;
    logic [3:0]  a4 = 0, b4 = 0, s4;
    // 32-bit instance
    logic        iv32 = 0, ir32, ov32, or32 = 0, ic32 = 0, oc32;
    logic [31:0] a32 = 0, b32 = 0, s32;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .i_c(ic16), .out_valid(ov16), .out_ready(or16), .sum(s16), .o_c(oc16)
    );
    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .i_c(ic4), .out_valid(ov4), .out_ready(or4), .sum(s4), .o_c(oc4)
    );
    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .i_c(ic32), .out_valid(ov32), .out_ready(or32), .sum(s32), .o_c(oc32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one 16-bit op from IDLE, check latency and the result, then drain it.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] exp_s, input logic exp_c, input string tag);
        int lat;
        a16 = a; b16 = b; ic16 = c; iv16 = 1;
        chk({tag, "_in_ready"}, 64'(ir16), 64'd1);
        tick();
        iv16 = 0;
        lat = 0;
        while (!ov16 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_sum"}, 64'(s16), 64'(exp_s));
        chk({tag, "_o_c"}, 64'(oc16), 64'(exp_c));
        or16 = 1;
        tick();
        or16 = 0;
        chk({tag, "_idle_after"}, 64'({ov16, ir16}), 64'b01);
    endtask

    logic [16:0] q16[$];
    logic [32:0] q32[$];

    initial begin
        int lat;
        logic [15:0] held_s;
        logic        held_c;
        int issued16, issued32, done16, done32;

        // Reset state
        #2;
        chk("rst16_state", 64'({ir16, ov16, oc16, s16}), {45'd0, 19'b1_0_0_0000000000000000});
        chk("rst4_state", 64'({ir4, ov4, oc4, s4}), 64'b1_0_0_0000);
        tick();
        rst_n = 1;

        op16(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, "basic");
        op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple");
        op16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "allones");

        // Backpressure with a new operation pending
        a16 = 16'h4321; b16 = 16'h1000; ic16 = 1; iv16 = 1;
        tick();
        a16 = 16'h0F0F; b16 = 16'h0101; ic16 = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_reach_done", 64'(ov16), 64'd1);
        held_s = s16; held_c = oc16;
        chk("bp_sum_value", 64'(held_s), 64'h5322);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", 64'({ov16, ir16, oc16, s16}), 64'({1'b1, 1'b0, held_c, held_s}));
        end
        or16 = 1;
        tick();
        or16 = 0;
        chk("bp_release", 64'({ov16, ir16, s16}), 64'({1'b0, 1'b1, held_s}));
        tick();
        iv16 = 0;
        chk("bp_new_accept", 64'(ir16), 64'd0);
        lat = 0;
        while (!ov16 && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_new_latency", 64'(lat), 64'd4);
        chk("bp_new_sum", 64'({oc16, s16}), 64'h1010);
        or16 = 1;
        tick();
        or16 = 0;

        // Reset in the second RUN clock
        a16 = 16'hABCD; b16 = 16'h1357; ic16 = 1; iv16 = 1;
        tick();
        iv16 = 0;
        tick();
        rst_n = 0;
        #1;
        chk("midrst_state", 64'({ov16, ir16, oc16, s16}), 64'({1'b0, 1'b1, 1'b0, 16'h0000}));
        tick();
        rst_n = 1;
        op16(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, "after_rst");

        // 4-bit instance: single-nibble latency
        a4 = 4'h9; b4 = 4'h8; ic4 = 0; iv4 = 1;
        tick();
        iv4 = 0;
        lat = 0;
        while (!ov4 && lat < 20) begin
            tick();
            lat++;
        end
        chk("w4_latency", 64'(lat), 64'd1);
        chk("w4_result", 64'({oc4, s4}), 64'h11);
        or4 = 1;
        tick();
        or4 = 0;

        // Random regression, 16 and 32 bits side by side
        issued16 = 0; issued32 = 0; done16 = 0; done32 = 0;
        for (int cyc = 0; cyc < 60000 && (done16 < 1000 || done32 < 1000); cyc++) begin
            iv16 = (issued16 < 1000) && ($urandom_range(0, 2) != 0);
            a16 = 16'($urandom); b16 = 16'($urandom); ic16 = 1'($urandom);
            or16 = ($urandom_range(0, 3) != 0);
            iv32 = (issued32 < 1000) && ($urandom_range(0, 2) != 0);
            a32 = $urandom; b32 = $urandom; ic32 = 1'($urandom);
            or32 = ($urandom_range(0, 3) != 0);

            if (iv16 && ir16) begin
                q16.push_back({1'b0, a16} + {1'b0, b16} + 17'(ic16));
                issued16++;
            end
            if (ov16 && or16) begin
                if (q16.size() == 0) chk("rnd16_spurious", 64'(done16), 64'(issued16 + 1));
                else chk("rnd16_result", 64'({oc16, s16}), 64'(q16.pop_front()));
                done16++;
            end
            if (iv32 && ir32) begin
                q32.push_back({1'b0, a32} + {1'b0, b32} + 33'(ic32));
                issued32++;
            end
            if (ov32 && or32) begin
                if (q32.size() == 0) chk("rnd32_spurious", 64'(done32), 64'(issued32 + 1));
                else chk("rnd32_result", 64'({oc32, s32}), 64'(q32.pop_front()));
                done32++;
            end
            tick();
        end
        iv16 = 0; or16 = 0; iv32 = 0; or32 = 0;
        chk("rnd16_count", 64'(done16), 64'd1000);
        chk("rnd32_count", 64'(done32), 64'd1000);
        chk("rnd16_leftover", 64'(q16.size()), 64'd0);
        chk("rnd32_leftover", 64'(q32.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
